// File: rtl/sw_debounce.sv
// sw_debounce: synchronizes a raw, bouncy switch input and accepts a new
// level only after it has been seen for STABLE_CYCLES consecutive samples.
// Produces the debounced level, one-cycle rise/fall pulses, and a
// saturating count of accepted presses.
`timescale 1ns/1ps
module sw_debounce #(
  parameter int STABLE_CYCLES = 4,  // legal range 2..255
  parameter int CNT_W         = 8   // must satisfy 2**CNT_W > STABLE_CYCLES
) (
  input  logic       clk,
  input  logic       rst,      // asynchronous, active-low
  input  logic       sw,
  output logic       db,
  output logic       rise,
  output logic       fall,
  output logic [7:0] presses
);

  // HIGH and WAIT_LOW share bit 1 = 1, so the encoding's MSB tracks db.
  typedef enum logic [1:0] {
    LOW       = 2'b00,
    WAIT_HIGH = 2'b01,
    HIGH      = 2'b11,
    WAIT_LOW  = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [7:0]       PRESS_MAX = 8'hFF;

  logic             r_sync1;
  logic             r_sync2;
  logic             w_sw_s;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  logic             w_db_next;
  logic             w_rise_next;
  logic             w_fall_next;

  logic             r_db;
  logic             r_rise;
  logic             r_fall;
  logic [7:0]       r_presses;

  // Two-flop synchronizer: the only path by which sw reaches the FSM.
  // NOTE: every flop here is cleared by the async reset, so no X ever
  // reaches the FSM and the block has a known state from the first edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make r_sync2 take the old r_sync1,
      // giving a true two-stage shift instead of a single collapsed flop.
      r_sync1 <= sw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sw_s = r_sync2;

  // FSM state and stability counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= LOW;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state, next-count and next-output decode.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal; without
    // them a missed branch would infer a latch.
    w_state_next = r_state;
    w_cnt_next   = r_cnt;

    case (r_state)
      LOW: begin
        if (w_sw_s) begin
          w_state_next = WAIT_HIGH;
          w_cnt_next   = CNT_ONE;
        end else begin
          w_cnt_next   = '0;
        end
      end

      WAIT_HIGH: begin
        if (!w_sw_s) begin
          // Level dropped before qualifying: abandon silently.
          w_state_next = LOW;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = HIGH;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt + CNT_ONE;
        end
      end

      HIGH: begin
        if (!w_sw_s) begin
          w_state_next = WAIT_LOW;
          w_cnt_next   = CNT_ONE;
        end else begin
          w_cnt_next   = '0;
        end
      end

      WAIT_LOW: begin
        if (w_sw_s) begin
          w_state_next = HIGH;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = LOW;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt + CNT_ONE;
        end
      end

      default: begin
        // Any corrupted encoding recovers to LOW on the next edge.
        w_state_next = LOW;
        w_cnt_next   = '0;
      end
    endcase

    // Outputs are decoded from the next state so the registered db/rise/fall
    // change on the same edge the FSM commits the transition.
    w_db_next   = (w_state_next == HIGH) || (w_state_next == WAIT_LOW);
    w_rise_next = (r_state == WAIT_HIGH) && (w_state_next == HIGH);
    w_fall_next = (r_state == WAIT_LOW)  && (w_state_next == LOW);
  end

  // Registered outputs and saturating press counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_db      <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
      r_presses <= 8'd0;
    end else begin
      r_db   <= w_db_next;
      r_rise <= w_rise_next;
      r_fall <= w_fall_next;
      if (w_rise_next && (r_presses != PRESS_MAX)) begin
        r_presses <= r_presses + 8'd1;
      end
    end
  end

  assign db      = r_db;
  assign rise    = r_rise;
  assign fall    = r_fall;
  assign presses = r_presses;

endmodule

// File: tb/tb_sw_debounce.sv
// Testbench for sw_debounce with STABLE_CYCLES=4, 80 ns clock.
`timescale 1ns/1ps
module tb_sw_debounce;

  logic       clk;
  logic       rst;
  logic       sw;
  logic       db;
  logic       rise;
  logic       fall;
  logic [7:0] presses;

  int n_checks;
  int n_errors;

  typedef struct {
    logic       sw;
    logic       db;
    logic       rise;
    logic       fall;
    logic [7:0] presses;
  } vec_t;

  vec_t vq[$];

  sw_debounce #(
    .STABLE_CYCLES(4),
    .CNT_W        (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sw     (sw),
    .db     (db),
    .rise   (rise),
    .fall   (fall),
    .presses(presses)
  );

  // 80 ns period, rising edges at 40, 120, 200, ...
  initial begin
    clk = 1'b0;
    forever #40 clk = ~clk;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one full clock; sampling happens on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic add_vec(input logic s, input logic d, input logic r,
                         input logic f, input logic [7:0] p);
    vec_t v;
    v.sw = s; v.db = d; v.rise = r; v.fall = f; v.presses = p;
    vq.push_back(v);
  endtask

  initial begin
    int rise_cnt;
    int fall_cnt;
    int exp_presses;

    n_checks = 0;
    n_errors = 0;

    // Bounce: 3 high, 1 low, 3 high, then low -> nothing accepted.
    add_vec(1, 0, 0, 0, 1);
    add_vec(1, 0, 0, 0, 1);
    add_vec(1, 0, 0, 0, 1);
    add_vec(0, 0, 0, 0, 1);
    add_vec(1, 0, 0, 0, 1);
    add_vec(1, 0, 0, 0, 1);
    add_vec(1, 0, 0, 0, 1);
    add_vec(0, 0, 0, 0, 1);
    add_vec(0, 0, 0, 0, 1);
    add_vec(0, 0, 0, 0, 1);
    add_vec(0, 0, 0, 0, 1);
    add_vec(0, 0, 0, 0, 1);
    add_vec(0, 0, 0, 0, 1);
    add_vec(0, 0, 0, 0, 1);
    // Exact threshold: 4 high samples are accepted; db high 4 cycles.
    add_vec(1, 0, 0, 0, 1);
    add_vec(1, 0, 0, 0, 1);
    add_vec(1, 0, 0, 0, 1);
    add_vec(1, 0, 0, 0, 1);
    add_vec(0, 0, 0, 0, 1);
    add_vec(0, 1, 1, 0, 2);
    add_vec(0, 1, 0, 0, 2);
    add_vec(0, 1, 0, 0, 2);
    add_vec(0, 1, 0, 0, 2);
    add_vec(0, 0, 0, 1, 2);
    add_vec(0, 0, 0, 0, 2);
    add_vec(0, 0, 0, 0, 2);

    // ---- Reset state and clean press with absolute timing ----
    rst = 1'b0;
    sw  = 1'b0;
    #5;
    check("reset_db", db, 0);
    check("reset_rise", rise, 0);
    check("reset_fall", fall, 0);
    check("reset_presses", presses, 0);
    #5 rst = 1'b1;          // t=10
    #103 sw = 1'b1;         // t=113, first sampling edge at 120
    #367;                   // t=480, after 5 edges
    check("press_db_edge5", db, 0);
    check("press_rise_edge5", rise, 0);
    #80;                    // t=560, after 6th edge (520)
    check("press_db_edge6", db, 1);
    check("press_rise_edge6", rise, 1);
    check("press_presses", presses, 1);
    #80;                    // t=640
    check("press_rise_1cyc", rise, 0);
    check("press_db_hold", db, 1);
    #374 sw = 1'b0;         // t=1014, first sampling edge at 1080
    #426;                   // t=1440, after 5 edges
    check("release_db_edge5", db, 1);
    check("release_fall_edge5", fall, 0);
    #80;                    // t=1520, after 6th edge (1480)
    check("release_db_edge6", db, 0);
    check("release_fall_edge6", fall, 1);
    check("release_presses", presses, 1);
    #80;                    // t=1600 (falling edge)
    check("release_fall_1cyc", fall, 0);

    // ---- Table-driven bounce and threshold ----
    foreach (vq[i]) begin
      sw = vq[i].sw;
      tick();
      check($sformatf("vec%0d_db", i), db, vq[i].db);
      check($sformatf("vec%0d_rise", i), rise, vq[i].rise);
      check($sformatf("vec%0d_fall", i), fall, vq[i].fall);
      check($sformatf("vec%0d_presses", i), presses, vq[i].presses);
      check($sformatf("vec%0d_excl", i), rise & fall, 0);
    end

    // ---- Reset in the middle of WAIT_HIGH ----
    sw = 1'b1;
    repeat (4) tick();      // sync, sync, WAIT_HIGH cnt=1, cnt=2
    check("midq_db_pre", db, 0);
    rst = 1'b0;
    tick();
    check("midq_db_rst", db, 0);
    check("midq_presses_rst", presses, 0);
    check("midq_rise_rst", rise, 0);
    tick();
    check("midq_db_rst2", db, 0);
    check("midq_presses_rst2", presses, 0);
    rst = 1'b1;             // sw still 1 at release
    for (int e = 1; e <= 5; e++) begin
      tick();
      check($sformatf("midq_db_e%0d", e), db, 0);
      check($sformatf("midq_rise_e%0d", e), rise, 0);
    end
    tick();
    check("midq_db_e6", db, 1);
    check("midq_rise_e6", rise, 1);
    check("midq_presses_e6", presses, 1);
    sw = 1'b0;
    repeat (10) tick();
    check("midq_db_released", db, 0);
    check("midq_presses_released", presses, 1);

    // ---- Saturation over 260 presses, starting from a cleared counter ----
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    exp_presses = 0;
    for (int p = 1; p <= 260; p++) begin
      rise_cnt = 0;
      fall_cnt = 0;
      sw = 1'b1;
      repeat (8) begin
        tick();
        rise_cnt += int'(rise);
      end
      sw = 1'b0;
      repeat (8) begin
        tick();
        fall_cnt += int'(fall);
      end
      exp_presses = (exp_presses < 255) ? exp_presses + 1 : 255;
      check($sformatf("sat_presses_p%0d", p), presses, 8'(exp_presses));
      check($sformatf("sat_rise_p%0d", p), 8'(rise_cnt), 1);
      check($sformatf("sat_fall_p%0d", p), 8'(fall_cnt), 1);
    end

    // ---- Asynchronous reset between clock edges while db=1 ----
    sw = 1'b1;
    repeat (8) tick();
    check("async_db_pre", db, 1);
    check("async_presses_pre", presses, 255);
    #10 rst = 1'b0;         // 10 ns after a falling edge, no rising edge yet
    #1;
    check("async_db", db, 0);
    check("async_presses", presses, 0);
    check("async_rise", rise, 0);
    check("async_fall", fall, 0);
    @(negedge clk);
    rst = 1'b1;
    sw  = 1'b0;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
